example_fig_8_9_checker: RTL and testbench

Synthesizable protocol checker for the Fig 8.9 design example (Start-triggered A/E/F sequencer). It sits on the observation side of that datapath. It watches the same `clock` and `Start` the sequencer receives, runs a cycle-exact reference model, and compares the sequencer's `A`, `E` and `F` outputs against that model every cycle. It reports completed runs, per-cycle mismatches, and sticky and saturating error statistics, for both the RTL and structural versions of the sequencer.

---
 rtl/example_fig_8_9_checker.sv | 149 ++++++++++++++
 tb/tb_example_fig_8_9_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/example_fig_8_9_checker.sv
`default_nettype none
// ============================================================================
//  Module   : example_fig_8_9_checker
//  Purpose  : Cycle-exact reference model and output comparator for the
//             Fig 8.9 Start-triggered A/E/F sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module example_fig_8_9_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       a_obs,
    input  logic             e_obs,
    input  logic             f_obs,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] run_count,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       mon_state
);

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_S1   = 2'd1,
        M_S2   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_load;
    logic             w_step;
    logic             w_finish;
    logic             w_cmp;

    logic [3:0]       r_ma;
    logic             r_me;
    logic             r_mf;
    logic             r_va;
    logic             r_ve;

    logic             r_done;
    logic             r_mismatch;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_run_count;
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= M_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            M_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = M_S1;
                end
            end
            M_S1: begin
                w_step = 1'b1;
                if (r_ma[3] & r_ma[2]) begin
                    w_state_next = M_S2;
                end
            end
            M_S2: begin
                w_finish     = 1'b1;
                w_state_next = M_IDLE;
            end
            default: begin
                w_state_next = M_IDLE;
            end
        endcase
    end

    // Model registers keep their values in M_IDLE so a finished run can still be compared.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ma <= 4'd0;
            r_me <= 1'b0;
            r_mf <= 1'b0;
            r_va <= 1'b0;
            r_ve <= 1'b0;
        end else begin
            if (w_load) begin
                r_ma <= 4'd0;
                r_mf <= 1'b0;
                r_va <= 1'b1;
            end
            if (w_step) begin
                r_ma <= r_ma + 4'd1;
                r_me <= r_ma[2];
                r_ve <= 1'b1;
            end
            if (w_finish) begin
                r_mf <= 1'b1;
            end
        end
    end

    assign w_cmp = (r_va & ((a_obs != r_ma) | (f_obs != r_mf)))
                 | (r_ve & (e_obs != r_me));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_done       <= 1'b0;
            r_mismatch   <= 1'b0;
            r_err_sticky <= 1'b0;
            r_run_count  <= '0;
            r_err_count  <= '0;
        end else begin
            r_done     <= w_finish;
            r_mismatch <= w_cmp;
            if (w_cmp) begin
                r_err_sticky <= 1'b1;
                if (r_err_count != c_CNT_MAX) begin
                    r_err_count <= r_err_count + c_CNT_ONE;
                end
            end
            if (w_finish && (r_run_count != c_CNT_MAX)) begin
                r_run_count <= r_run_count + c_CNT_ONE;
            end
        end
    end

    assign busy       = (r_state == M_S1) || (r_state == M_S2);
    assign done       = r_done;
    assign mismatch   = r_mismatch;
    assign err_sticky = r_err_sticky;
    assign run_count  = r_run_count;
    assign err_count  = r_err_count;
    assign mon_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_example_fig_8_9_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_example_fig_8_9_checker
//  Purpose  : Drives a golden Fig 8.9 sequencer into two checker instances
//             (CNT_W=8 and CNT_W=2) with optional fault injection.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_example_fig_8_9_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       fa = 1'b0;
    logic       fe = 1'b0;

    always #5 clk = ~clk;

    // Golden sequencer; reset values deliberately disagree with the checker model.
    logic [3:0] sa;
    logic       se, sf;
    logic [1:0] sst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sst <= 2'd0;
            sa  <= 4'hA;
            se  <= 1'b1;
            sf  <= 1'b1;
        end else begin
            case (sst)
                2'd0: if (start) begin
                    sa  <= 4'd0;
                    sf  <= 1'b0;
                    sst <= 2'd1;
                end
                2'd1: begin
                    sa <= sa + 4'd1;
                    se <= sa[2];
                    if (sa[3] & sa[2]) sst <= 2'd2;
                end
                default: begin
                    sf  <= 1'b1;
                    sst <= 2'd0;
                end
            endcase
        end
    end

    logic [3:0] a_obs;
    logic       e_obs, f_obs;
    assign a_obs = fa ? 4'd5 : sa;
    assign e_obs = se ^ fe;
    assign f_obs = sf;

    logic       busy8, done8, mm8, st8;
    logic [7:0] run8, err8;
    logic [1:0] ms8;
    logic       busy2, done2, mm2, st2;
    logic [1:0] run2, err2;
    logic [1:0] ms2;

    example_fig_8_9_checker #(.CNT_W(8)) dut8 (
        .clock(clk), .reset(reset), .start(start),
        .a_obs(a_obs), .e_obs(e_obs), .f_obs(f_obs),
        .busy(busy8), .done(done8), .mismatch(mm8), .err_sticky(st8),
        .run_count(run8), .err_count(err8), .mon_state(ms8)
    );

    example_fig_8_9_checker #(.CNT_W(2)) dut2 (
        .clock(clk), .reset(reset), .start(start),
        .a_obs(a_obs), .e_obs(e_obs), .f_obs(f_obs),
        .busy(busy2), .done(done2), .mismatch(mm2), .err_sticky(st2),
        .run_count(run2), .err_count(err2), .mon_state(ms2)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic mm;
        logic dn;
        int   r8, r2, e8, e2;
        logic st;
    } exp_t;

    exp_t sbq[$];
    int   m_r8 = 0, m_r2 = 0, m_e8 = 0, m_e2 = 0;
    logic m_st = 1'b0;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock: drive inputs, push expectation, compare after the edge.
    task automatic step(input logic s, input logic a, input logic e);
        exp_t x;
        start = s;
        fa    = a;
        fe    = e;
        x.mm  = a | e;
        x.dn  = (sst == 2'd2);
        m_r8  = sat(m_r8 + int'(x.dn), 255);
        m_r2  = sat(m_r2 + int'(x.dn), 3);
        m_e8  = sat(m_e8 + int'(x.mm), 255);
        m_e2  = sat(m_e2 + int'(x.mm), 3);
        m_st  = m_st | x.mm;
        x.r8 = m_r8; x.r2 = m_r2; x.e8 = m_e8; x.e2 = m_e2; x.st = m_st;
        sbq.push_back(x);
        @(posedge clk);
        @(negedge clk);
        x = sbq.pop_front();
        chk("mismatch8", mm8, x.mm);
        chk("mismatch2", mm2, x.mm);
        chk("done8", done8, x.dn);
        chk("done2", done2, x.dn);
        chk("run_count8", run8, x.r8);
        chk("run_count2", run2, x.r2);
        chk("err_count8", err8, x.e8);
        chk("err_count2", err2, x.e2);
        chk("err_sticky8", st8, x.st);
        chk("err_sticky2", st2, x.st);
        chk("mon_state8", ms8, sst);
        chk("busy8", busy8, int'(sst != 2'd0));
        chk("busy2", busy2, int'(sst != 2'd0));
    endtask

    typedef struct {
        logic rst;
        logic s, a, e;
        int   n;
        int   r8, r2, e8, e2;
        logic st;
    } phase_t;

    phase_t tbl[22];

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl = '{
            '{1'b1, 1'b0, 1'b0, 1'b0,  0, 0, 0, 0, 0, 1'b0},  // async reset
            '{1'b0, 1'b0, 1'b0, 1'b0,  3, 0, 0, 0, 0, 1'b0},  // idle, uncompared junk
            '{1'b0, 1'b1, 1'b0, 1'b0,  1, 0, 0, 0, 0, 1'b0},  // clean run
            '{1'b0, 1'b0, 1'b0, 1'b0, 14, 1, 1, 0, 0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0,  1, 1, 1, 0, 0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0,  1, 1, 1, 0, 0, 1'b0},  // A fault at ma=3
            '{1'b0, 1'b0, 1'b0, 1'b0,  3, 1, 1, 0, 0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0,  1, 1, 1, 1, 1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2, 2, 1, 1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0,  1, 2, 2, 1, 1, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b0, 40, 4, 3, 1, 1, 1'b1},  // start held high
            '{1'b0, 1'b0, 1'b0, 1'b0,  5, 5, 3, 1, 1, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b0,  1, 5, 3, 1, 1, 1'b1},  // run to ma=7
            '{1'b0, 1'b0, 1'b0, 1'b0,  7, 5, 3, 1, 1, 1'b1},
            '{1'b1, 1'b0, 1'b0, 1'b0,  0, 0, 0, 0, 0, 1'b0},  // reset mid-run
            '{1'b0, 1'b1, 1'b0, 1'b0,  1, 0, 0, 0, 0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 15, 1, 1, 0, 0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0,  1, 1, 1, 0, 0, 1'b0},  // E inversion x6
            '{1'b0, 1'b0, 1'b0, 1'b0,  1, 1, 1, 0, 0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b1,  6, 1, 1, 6, 3, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0,  7, 2, 2, 6, 3, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0,  1, 2, 2, 6, 3, 1'b1}
        };

        @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            if (tbl[i].rst) begin
                #2 reset = 1'b1;
                #1;
                chk("rst_busy8", busy8, 0);
                chk("rst_done8", done8, 0);
                chk("rst_mismatch8", mm8, 0);
                chk("rst_sticky8", st8, 0);
                chk("rst_run8", run8, 0);
                chk("rst_err8", err8, 0);
                chk("rst_state8", ms8, 0);
                chk("rst_state2", ms2, 0);
                chk("rst_run2", run2, 0);
                chk("rst_err2", err2, 0);
                @(negedge clk);
                reset = 1'b0;
                m_r8 = 0; m_r2 = 0; m_e8 = 0; m_e2 = 0; m_st = 1'b0;
            end else begin
                for (int k = 0; k < tbl[i].n; k++) begin
                    step(tbl[i].s, tbl[i].a, tbl[i].e);
                end
                chk("phase_run8", run8, tbl[i].r8);
                chk("phase_run2", run2, tbl[i].r2);
                chk("phase_err8", err8, tbl[i].e8);
                chk("phase_err2", err2, tbl[i].e2);
                chk("phase_sticky8", st8, tbl[i].st);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
